// File: rtl/oh_aoi_pipe_stage.sv
// Stage-count limit for the oh_aoi pipeline; the stage register itself is in oh_aoi_stage.sv.
package oh_aoi_pipe_stage_pkg;
  localparam int unsigned STAGE_MAX = 4;
endpackage

// File: rtl/oh_aoi_pkg.sv
// Shared mode encodings and operand addressing for the oh_aoi pipelined AOI cell.
package oh_aoi_pkg;

  localparam logic [1:0] AOI = 2'b00;
  localparam logic [1:0] AO  = 2'b01;
  localparam logic [1:0] OAI = 2'b10;
  localparam logic [1:0] OA  = 2'b11;

  // Bit offset of term t, input k inside the flat operand bus.
  function automatic int unsigned term_off(input int unsigned t,
                                           input int unsigned k,
                                           input int unsigned kn,
                                           input int unsigned dw);
    return ((t * kn) + k) * dw;
  endfunction

endpackage

// File: rtl/oh_aoi_stage.sv
// One valid/ready pipeline stage: DW-bit data register plus valid bit, bubble-collapsing enable.
module oh_aoi_stage
  import oh_aoi_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en_out,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  output logic          en_in,
  output logic          valid,
  output logic [DW-1:0] data
);

  // An empty stage always accepts; a full one only when downstream moves.
  assign en_in = ~valid | en_out;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en_in) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/oh_aoi_pipe.sv
// Pipelined AND-OR-INVERT / OR-AND-INVERT cell with valid/ready stages and a saturating beat counter.
module oh_aoi_pipe
  import oh_aoi_pkg::*;
#(
  parameter int unsigned DW     = 1,
  parameter int unsigned N      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CW     = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [N*K*DW-1:0] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     z,
  output logic [CW-1:0]     cnt,
  input  logic              cnt_clear
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DW-1:0] and_term;
  logic [DW-1:0] or_term;
  logic [DW-1:0] sop;
  logic [DW-1:0] pos;
  logic [DW-1:0] f;

  // Sum-of-products and product-of-sums are both formed; mode picks one.
  always_comb begin
    sop      = '0;
    pos      = '1;
    and_term = '0;
    or_term  = '0;
    for (int unsigned t = 0; t < N; t++) begin
      and_term = '1;
      or_term  = '0;
      for (int unsigned k = 0; k < K; k++) begin
        and_term = and_term & in[term_off(t, k, K, DW) +: DW];
        or_term  = or_term  | in[term_off(t, k, K, DW) +: DW];
      end
      sop = sop | and_term;
      pos = pos & or_term;
    end
  end

  always_comb begin
    f = pos;
    case (mode)
      AOI:     f = ~sop;
      AO:      f = sop;
      OAI:     f = ~pos;
      default: f = pos;
    endcase
  end

  generate
    if (STAGES == 0) begin : g_pass
      assign z         = f;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
    end else begin : g_pipe
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          en_w;
        logic          en_nxt;
        logic          vld_w;
        logic          vin;
        logic [DW-1:0] dat_w;
        logic [DW-1:0] din;

        if (i == STAGES - 1) begin : g_last
          assign en_nxt = out_ready;
        end else begin : g_mid
          assign en_nxt = g_stage[i+1].en_w;
        end

        if (i == 0) begin : g_first
          assign vin = in_valid;
          assign din = f;
        end else begin : g_next
          assign vin = g_stage[i-1].vld_w;
          assign din = g_stage[i-1].dat_w;
        end

        oh_aoi_stage #(.DW(DW)) u_stage (
          .clk      (clk),
          .nreset   (nreset),
          .en_out   (en_nxt),
          .valid_in (vin),
          .data_in  (din),
          .en_in    (en_w),
          .valid    (vld_w),
          .data     (dat_w)
        );
      end

      assign in_ready  = g_stage[0].en_w;
      assign out_valid = g_stage[STAGES-1].vld_w;
      assign z         = g_stage[STAGES-1].dat_w;
    end
  endgenerate

  // Delivered-beat counter; clear wins over an increment and the count never wraps.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (cnt_clear) begin
      cnt <= '0;
    end else if (out_valid && out_ready && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_oh_aoi_pipe.sv
// Self-checking bench for oh_aoi_pipe: vector table, scoreboarded streams, STAGES=0 random, counter and reset corners.
module tb_oh_aoi_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  int   checks   = 0;
  int   failures = 0;

  // DUT A: DW=4 N=2 K=2 STAGES=2 CW=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clear;
  logic [1:0]  a_mode;
  logic [15:0] a_in;
  logic [3:0]  a_z;
  logic [15:0] a_cnt;

  // DUT B: DW=8 N=3 K=2 STAGES=0 CW=16
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clear;
  logic [1:0]  b_mode;
  logic [47:0] b_in;
  logic [7:0]  b_z;
  logic [15:0] b_cnt;

  // DUT C: DW=4 N=2 K=2 STAGES=1 CW=3
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_cnt_clear;
  logic [1:0]  c_mode;
  logic [15:0] c_in;
  logic [3:0]  c_z;
  logic [2:0]  c_cnt;

  oh_aoi_pipe #(.DW(4), .N(2), .K(2), .STAGES(2), .CW(16)) u_a (
    .clk(clk), .nreset(nreset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mode(a_mode), .in(a_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .z(a_z), .cnt(a_cnt), .cnt_clear(a_cnt_clear)
  );

  oh_aoi_pipe #(.DW(8), .N(3), .K(2), .STAGES(0), .CW(16)) u_b (
    .clk(clk), .nreset(nreset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .in(b_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .z(b_z), .cnt(b_cnt), .cnt_clear(b_cnt_clear)
  );

  oh_aoi_pipe #(.DW(4), .N(2), .K(2), .STAGES(1), .CW(3)) u_c (
    .clk(clk), .nreset(nreset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .mode(c_mode), .in(c_in), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .z(c_z), .cnt(c_cnt), .cnt_clear(c_cnt_clear)
  );

  typedef struct {
    logic [15:0] din;
    logic [1:0]  mode;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    logic [3:0] z;
    int         e;
  } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];
  int   edge_n  = 0;
  int   lat_chk = 0;
  int   a_del_n = 0;
  int   a_acc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-lane reference: count ones in each term, then apply the mode rules.
  function automatic logic [7:0] ref_f(input logic [63:0] v, input int dw, input int n,
                                       input int k, input logic [1:0] m);
    logic [7:0] r;
    int any_t, all_t, ones;
    bit rb;
    r = '0;
    for (int l = 0; l < dw; l++) begin
      any_t = 0;
      all_t = 1;
      for (int t = 0; t < n; t++) begin
        ones = 0;
        for (int j = 0; j < k; j++) if (v[(t*k+j)*dw+l]) ones++;
        if (ones == k) any_t = 1;
        if (ones == 0) all_t = 0;
      end
      rb   = m[1] ? (all_t != 0) : (any_t != 0);
      r[l] = m[0] ? rb : ~rb;
    end
    return r;
  endfunction

  // Drive DUT A for one cycle (called at negedge, returns at next negedge) with scoreboarding.
  task automatic a_cycle(input logic v, input logic [15:0] d, input logic [1:0] m, input logic ordy);
    exp_t x;
    a_in_valid  = v;
    a_in        = d;
    a_mode      = m;
    a_out_ready = ordy;
    #1;
    if (a_out_valid && a_out_ready) begin
      a_del_n++;
      if (sbq.size() == 0) begin
        chk("a_spurious_out", 64'd1, 64'd0);
      end else begin
        x = sbq.pop_front();
        chk("a_z_order", 64'(a_z), 64'(x.z));
        if (lat_chk != 0) chk("a_latency", 64'(edge_n + 1 - x.e), 64'd2);
      end
    end
    if (a_in_valid && a_in_ready) begin
      a_acc_n++;
      x.z = 4'(ref_f(64'(d), 4, 2, 2, m));
      x.e = edge_n + 1;
      sbq.push_back(x);
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] held;
    int exp_b_cnt;

    tbl[0] = '{16'hF03F, 2'b00, 4'hC};
    tbl[1] = '{16'hF03F, 2'b01, 4'h3};
    tbl[2] = '{16'hF03F, 2'b10, 4'h0};
    tbl[3] = '{16'hF03F, 2'b11, 4'hF};
    tbl[4] = '{16'h0000, 2'b00, 4'hF};
    tbl[5] = '{16'hFFFF, 2'b10, 4'h0};
    tbl[6] = '{16'h0000, 2'b11, 4'h0};

    nreset = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_cnt_clear = 0; a_mode = 0; a_in = 0;
    b_in_valid = 0; b_out_ready = 0; b_cnt_clear = 0; b_mode = 0; b_in = 0;
    c_in_valid = 0; c_out_ready = 0; c_cnt_clear = 0; c_mode = 0; c_in = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_z", 64'(a_z), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_c_out_valid", 64'(c_out_valid), 64'd0);
    chk("rst_c_in_ready", 64'(c_in_ready), 64'd1);
    nreset = 1'b1;

    // Vector table: one beat at a time, visible two cycles after acceptance.
    for (int i = 0; i < 7; i++) begin
      a_cycle(1'b1, tbl[i].din, tbl[i].mode, 1'b1);
      chk("tbl_not_early", 64'(a_out_valid), 64'd0);
      a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
      chk("tbl_valid", 64'(a_out_valid), 64'd1);
      chk("tbl_z", 64'(a_z), 64'(tbl[i].exp));
      a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
    end
    chk("tbl_cnt", 64'(a_cnt), 64'd7);

    a_cnt_clear = 1'b1;
    a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
    a_cnt_clear = 1'b0;
    chk("clr_a_cnt", 64'(a_cnt), 64'd0);

    // Back-to-back random beats at full throughput.
    lat_chk = 1; a_del_n = 0; a_acc_n = 0;
    for (int i = 0; i < 8; i++) a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b1);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("b2b_accepts", 64'(a_acc_n), 64'd8);
    chk("b2b_drained", 64'(sbq.size()), 64'd0);
    chk("b2b_delivered", 64'(a_del_n), 64'd8);
    chk("b2b_cnt", 64'(a_cnt), 64'd8);

    // Fill with downstream stalled, check hold, then release.
    lat_chk = 0; a_del_n = 0; a_acc_n = 0;
    for (int i = 0; i < 4; i++) a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b0);
    chk("fill_accepts", 64'(a_acc_n), 64'd2);
    chk("fill_in_ready", 64'(a_in_ready), 64'd0);
    chk("fill_out_valid", 64'(a_out_valid), 64'd1);
    held = a_z;
    a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b0);
    a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b0);
    chk("fill_z_hold", 64'(a_z), 64'(held));
    chk("fill_still_full", 64'(a_acc_n), 64'd2);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    #1;
    chk("full_pass_ready", 64'(a_in_ready), 64'd1);
    a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b1);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("fill_drained", 64'(sbq.size()), 64'd0);
    chk("fill_delivered", 64'(a_del_n), 64'd3);

    // Combinational passthrough against the reference model.
    exp_b_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      b_in        = 48'({$urandom, $urandom});
      b_mode      = 2'($urandom);
      b_in_valid  = 1'($urandom);
      b_out_ready = 1'($urandom);
      #1;
      chk("b_z", 64'(b_z), 64'(ref_f(64'(b_in), 8, 3, 2, b_mode)));
      chk("b_out_valid", 64'(b_out_valid), 64'(b_in_valid));
      chk("b_in_ready", 64'(b_in_ready), 64'(b_out_ready));
      if (b_in_valid && b_out_ready) exp_b_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    chk("b_cnt", 64'(b_cnt), 64'(exp_b_cnt));

    // Small counter saturation, then clear coinciding with a delivery.
    c_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c_in_valid = 1'b1;
      c_in = 16'($urandom);
      c_mode = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    c_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("c_cnt_sat", 64'(c_cnt), 64'd7);
    c_in = 16'hF03F; c_mode = 2'b00; c_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 1'b0; c_cnt_clear = 1'b1;
    #1;
    chk("c_out_valid", 64'(c_out_valid), 64'd1);
    chk("c_z", 64'(c_z), 64'hC);
    @(posedge clk);
    @(negedge clk);
    c_cnt_clear = 1'b0;
    chk("c_clear_wins", 64'(c_cnt), 64'd0);
    c_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("c_cnt_after_clear", 64'(c_cnt), 64'd1);

    // Reset with two beats in flight.
    a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b0);
    a_cycle(1'b1, 16'($urandom), 2'($urandom), 1'b0);
    chk("mid_pre_valid", 64'(a_out_valid), 64'd1);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_z", 64'(a_z), 64'd0);
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mid_rst_cnt", 64'(a_cnt), 64'd0);
    sbq.delete();
    @(negedge clk);
    nreset = 1'b1;
    a_del_n = 0;
    for (int i = 0; i < 5; i++) a_cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("mid_no_stale", 64'(a_del_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
